// File: rtl/force_accum_cache_array.sv
// Per-cell force accumulation cache: per-channel input FIFO feeding a 2-stage
// read-modify-write pipeline with saturating adds, MU read port and a clear sweep.
module force_accum_cache_array #(
    parameter int NUM_CH        = 8,
    parameter int DW            = 32,
    parameter int ID_W          = 4,
    parameter int FIFO_DEPTH    = 16,
    parameter int CLEAR_ON_READ = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CH-1:0]      in_valid,
    input  logic [NUM_CH*ID_W-1:0] in_id,
    input  logic [NUM_CH*3*DW-1:0] in_force,
    output logic [NUM_CH-1:0]      in_ready,
    input  logic                   clear_all,
    input  logic [NUM_CH-1:0]      rd_req,
    input  logic [ID_W-1:0]        rd_addr,
    output logic [NUM_CH*3*DW-1:0] out_force,
    output logic [NUM_CH*ID_W-1:0] out_id,
    output logic [NUM_CH-1:0]      out_valid,
    output logic                   busy,
    output logic                   all_empty,
    output logic [NUM_CH-1:0]      sat_flag,
    output logic [NUM_CH-1:0]      ovf_flag
);
    localparam int   DEPTH  = 2**ID_W;
    localparam int   FW     = 3*DW;
    localparam int   AW     = $clog2(FIFO_DEPTH);
    localparam int   PW     = AW + 1;
    localparam logic CLR_RD = (CLEAR_ON_READ != 0);

    typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] cnt_q, cnt_d;
    logic            idle_s;
    logic [NUM_CH-1:0] empty_v, inflight_v;

    // Three independent signed saturating adds; MSB of the result flags any clamp.
    function automatic logic [FW:0] sat_add3(input logic [FW-1:0] a, input logic [FW-1:0] b);
        logic [FW-1:0] r;
        logic          sat;
        logic          ovf;
        logic [DW-1:0] ac, bc, sc;
        r   = '0;
        sat = 1'b0;
        for (int c = 0; c < 3; c++) begin
            ac  = a[c*DW +: DW];
            bc  = b[c*DW +: DW];
            sc  = ac + bc;
            ovf = (ac[DW-1] == bc[DW-1]) && (sc[DW-1] != ac[DW-1]);
            r[c*DW +: DW] = ovf ? {ac[DW-1], {(DW-1){~ac[DW-1]}}} : sc;
            sat = sat | ovf;
        end
        return {sat, r};
    endfunction

    assign idle_s    = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_CLEAR);
    // S1 is counted as in flight too, so a popped but unwritten update keeps this low.
    assign all_empty = (&empty_v) & ~(|inflight_v) & idle_s;

    // Clear-sweep FSM next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_all) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + ID_W'(1'b1);
                if (cnt_q == {ID_W{1'b1}}) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state register; reset starts a full sweep.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [ID_W+FW-1:0] fifo_mem [FIFO_DEPTH];
        logic [FW-1:0]      cache_mem [DEPTH];
        logic [PW-1:0]      wp_q, wp_d, rp_q, rp_d;
        logic               s1_v_q, s1_v_d, s2_v_q, s2_v_d;
        logic [ID_W-1:0]    s1_id_q, s1_id_d, s2_id_q, s2_id_d;
        logic [FW-1:0]      s1_inc_q, s1_inc_d, s2_sum_q, s2_sum_d;
        logic               sat_q, sat_d, ovf_q, ovf_d, out_v_q, out_v_d;
        logic [ID_W-1:0]    out_id_q, out_id_d;
        logic [FW-1:0]      out_f_q, out_f_d;
        logic               full_s, empty_s, push_s, pop_s, rd_s, rd_clr_s, s2_we_s;
        logic [FW-1:0]      base_s;
        logic [FW:0]        add_s;

        assign empty_s  = (wp_q == rp_q);
        assign full_s   = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
        assign push_s   = in_valid[g] & ~full_s & idle_s;
        // Pops wait out a clear request so queued updates survive the sweep.
        assign pop_s    = ~empty_s & idle_s & ~clear_all & ~rd_req[g];
        assign rd_s     = rd_req[g] & idle_s;
        assign rd_clr_s = rd_s & CLR_RD;
        assign s2_we_s  = s2_v_q & idle_s;

        assign in_ready[g]                = ~full_s & idle_s;
        assign empty_v[g]                 = empty_s;
        assign inflight_v[g]              = s1_v_q | s2_v_q;
        assign out_force[g*FW +: FW]      = out_f_q;
        assign out_id[g*ID_W +: ID_W]     = out_id_q;
        assign out_valid[g]               = out_v_q;
        assign sat_flag[g]                = sat_q;
        assign ovf_flag[g]                = ovf_q;

        // Accumulate base: a same-cycle clear-on-read beats the S2 forward, which beats memory.
        always_comb begin
            if (rd_clr_s && (rd_addr == s1_id_q)) begin
                base_s = '0;
            end else if (s2_we_s && (s2_id_q == s1_id_q)) begin
                base_s = s2_sum_q;
            end else begin
                base_s = cache_mem[s1_id_q];
            end
        end

        assign add_s = sat_add3(base_s, s1_inc_q);

        // Pointer, pipeline, flag and read-port next state.
        always_comb begin
            wp_d     = wp_q + PW'(push_s);
            rp_d     = rp_q + PW'(pop_s);
            s1_v_d   = pop_s;
            s1_id_d  = s1_id_q;
            s1_inc_d = s1_inc_q;
            s2_v_d   = s1_v_q & idle_s;
            s2_id_d  = s1_id_q;
            s2_sum_d = add_s[FW-1:0];
            sat_d    = sat_q | (s1_v_q & idle_s & add_s[FW]);
            ovf_d    = ovf_q | (in_valid[g] & full_s);
            out_v_d  = rd_s;
            out_id_d = out_id_q;
            out_f_d  = out_f_q;
            if (pop_s) begin
                {s1_id_d, s1_inc_d} = fifo_mem[rp_q[AW-1:0]];
            end else begin
                s1_id_d = s1_id_q;
            end
            if (rd_s) begin
                out_id_d = rd_addr;
                out_f_d  = (s2_we_s && (s2_id_q == rd_addr)) ? s2_sum_q : cache_mem[rd_addr];
            end else begin
                out_id_d = out_id_q;
            end
        end

        // Control and output registers.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                wp_q     <= '0;
                rp_q     <= '0;
                s1_v_q   <= 1'b0;
                s1_id_q  <= '0;
                s1_inc_q <= '0;
                s2_v_q   <= 1'b0;
                s2_id_q  <= '0;
                s2_sum_q <= '0;
                sat_q    <= 1'b0;
                ovf_q    <= 1'b0;
                out_v_q  <= 1'b0;
                out_id_q <= '0;
                out_f_q  <= '0;
            end else begin
                wp_q     <= wp_d;
                rp_q     <= rp_d;
                s1_v_q   <= s1_v_d;
                s1_id_q  <= s1_id_d;
                s1_inc_q <= s1_inc_d;
                s2_v_q   <= s2_v_d;
                s2_id_q  <= s2_id_d;
                s2_sum_q <= s2_sum_d;
                sat_q    <= sat_d;
                ovf_q    <= ovf_d;
                out_v_q  <= out_v_d;
                out_id_q <= out_id_d;
                out_f_q  <= out_f_d;
            end
        end

        // FIFO storage.
        always_ff @(posedge clk) begin
            if (push_s) begin
                fifo_mem[wp_q[AW-1:0]] <= {in_id[g*ID_W +: ID_W], in_force[g*FW +: FW]};
            end
        end

        // Cache storage; a read-clear is ordered after the S2 write so clear wins on the same id.
        always_ff @(posedge clk) begin
            if (busy) begin
                cache_mem[cnt_q] <= '0;
            end else begin
                if (s2_we_s) begin
                    cache_mem[s2_id_q] <= s2_sum_q;
                end
                if (rd_clr_s) begin
                    cache_mem[rd_addr] <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_force_accum_cache_array.sv
// Scoreboard bench for force_accum_cache_array: a bench-side cache model predicts every read.
module tb_force_accum_cache_array;
    localparam int NCH = 8;
    localparam int FW  = 96;
    localparam bit CLR = 1'b1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NCH-1:0]  in_valid = '0;
    logic [NCH*4-1:0] in_id = '0;
    logic [NCH*FW-1:0] in_force = '0;
    logic [NCH-1:0]  in_ready;
    logic            clear_all = 1'b0;
    logic [NCH-1:0]  rd_req = '0;
    logic [3:0]      rd_addr = '0;
    logic [NCH*FW-1:0] out_force;
    logic [NCH*4-1:0] out_id;
    logic [NCH-1:0]  out_valid;
    logic            busy, all_empty;
    logic [NCH-1:0]  sat_flag, ovf_flag;

    force_accum_cache_array dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_id(in_id), .in_force(in_force),
        .in_ready(in_ready), .clear_all(clear_all), .rd_req(rd_req), .rd_addr(rd_addr),
        .out_force(out_force), .out_id(out_id), .out_valid(out_valid), .busy(busy),
        .all_empty(all_empty), .sat_flag(sat_flag), .ovf_flag(ovf_flag)
    );

    always #5 clk = ~clk;

    typedef struct { int ch; logic [3:0] id; logic [FW-1:0] f; } exp_t;
    typedef struct { logic [3:0] id; logic [FW-1:0] f; } pend_t;

    exp_t        sb_q[$];
    pend_t       pend_q[NCH][$];
    logic [FW-1:0] mem_m [NCH][16];
    logic [NCH-1:0] exp_sat;
    logic [NCH-1:0] exp_ovf;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          nb;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [FW:0] add3m(input logic [FW-1:0] a, input logic [FW-1:0] b);
        logic [FW-1:0]      r;
        logic               sat;
        logic signed [31:0] av, bv;
        longint             s;
        r   = '0;
        sat = 1'b0;
        for (int c = 0; c < 3; c++) begin
            av = a[c*32 +: 32];
            bv = b[c*32 +: 32];
            s  = longint'(av) + longint'(bv);
            if (s > 64'sd2147483647) begin
                s = 64'sd2147483647;
                sat = 1'b1;
            end else if (s < -64'sd2147483648) begin
                s = -64'sd2147483648;
                sat = 1'b1;
            end
            r[c*32 +: 32] = s[31:0];
        end
        return {sat, r};
    endfunction

    function automatic logic [FW-1:0] fz(input int x, input int y, input int z);
        return {z[31:0], y[31:0], x[31:0]};
    endfunction

    task automatic reset_model();
        for (int c = 0; c < NCH; c++) begin
            pend_q[c].delete();
            for (int i = 0; i < 16; i++) mem_m[c][i] = '0;
        end
        exp_sat = '0;
        exp_ovf = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        in_valid  = '0;
        rd_req    = '0;
        clear_all = 1'b0;
    endtask

    task automatic push1(input int ch, input logic [3:0] id, input logic [FW-1:0] f, input bit accept);
        pend_t p;
        check_eq($sformatf("in_ready_ch%0d", ch), in_ready[ch], accept);
        in_valid[ch]          = 1'b1;
        in_id[ch*4 +: 4]      = id;
        in_force[ch*FW +: FW] = f;
        p.id = id;
        p.f  = f;
        if (accept) pend_q[ch].push_back(p);
    endtask

    task automatic rd1(input int ch, input logic [3:0] id);
        exp_t e;
        rd_req[ch] = 1'b1;
        rd_addr    = id;
        e.ch = ch;
        e.id = id;
        e.f  = mem_m[ch][id];
        sb_q.push_back(e);
        if (CLR) mem_m[ch][id] = '0;
    endtask

    task automatic apply_pending();
        pend_t       p;
        logic [FW:0] r;
        for (int c = 0; c < NCH; c++) begin
            while (pend_q[c].size() > 0) begin
                p = pend_q[c].pop_front();
                r = add3m(mem_m[c][p.id], p.f);
                mem_m[c][p.id] = r[FW-1:0];
                if (r[FW]) exp_sat[c] = 1'b1;
            end
        end
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        tick();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (all_empty) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check_eq("drain_timeout", all_empty, 1'b1);
        apply_pending();
    endtask

    task automatic count_busy(input int pulse_k, output int n);
        n = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            clear_all = (k == pulse_k);
            if (busy) begin
                n++;
            end else begin
                clear_all = 1'b0;
                break;
            end
        end
        clear_all = 1'b0;
    endtask

    // Read-port monitor: every out_valid pulse must match the oldest expected read.
    always @(negedge clk) begin
        exp_t e;
        for (int c = 0; c < NCH; c++) begin
            if (out_valid[c] === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check_eq("spurious_out_valid", out_valid[c], 1'b0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("rd_ch", c, e.ch);
                    check_eq("rd_id", out_id[c*4 +: 4], e.id);
                    check_eq("rd_force", out_force[c*FW +: FW], e.f);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", busy, 1'b1);
        check_eq("rst_out_valid", out_valid, 8'h00);
        check_eq("rst_sat", sat_flag, 8'h00);
        check_eq("rst_ovf", ovf_flag, 8'h00);
        @(posedge clk);
        #1 rst = 1'b1;
        count_busy(-1, nb);
        check_eq("busy_len", nb, 16);
        check_eq("ready_all", in_ready, 8'hFF);
        check_eq("all_empty_idle", all_empty, 1'b1);
        for (int i = 0; i < 16; i++) begin
            tick();
            rd1(0, 4'(i));
        end

        // Back-to-back accumulation into one id.
        tick(); push1(2, 4'd5, fz(3, 0, 0), 1'b1);
        tick(); push1(2, 4'd5, fz(4, 0, 0), 1'b1);
        tick(); push1(2, 4'd5, fz(-2, 0, 0), 1'b1);
        wait_drain();
        tick(); rd1(2, 4'd5);
        tick(); rd1(2, 4'd5);

        // Positive clamp on ch0 x, negative clamp on ch4 z.
        tick();
        push1(0, 4'd1, fz(32'h7FFF_FFF0, 0, 0), 1'b1);
        push1(4, 4'd1, fz(0, 0, 32'h8000_0010), 1'b1);
        tick();
        push1(0, 4'd1, fz(32'h20, 0, 0), 1'b1);
        push1(4, 4'd1, fz(0, 0, -32), 1'b1);
        wait_drain();
        check_eq("sat_flag", sat_flag, exp_sat);
        tick(); rd1(0, 4'd1);
        tick(); rd1(4, 4'd1);

        // FIFO fill while reads hold off the drain; 17th push overflows.
        for (int k = 0; k < 17; k++) begin
            tick();
            rd1(3, 4'd9);
            push1(3, 4'd2, fz(1, 0, 0), (k < 16));
            if (k == 16) exp_ovf[3] = 1'b1;
        end
        tick();
        @(negedge clk);
        check_eq("ovf_flag", ovf_flag, exp_ovf);
        wait_drain();
        tick(); rd1(3, 4'd2);

        // Clear sweep with updates still queued; re-pulse mid-sweep.
        for (int k = 0; k < 4; k++) begin
            tick();
            rd1(1, 4'd12);
            push1(1, 4'd7, fz(1, 0, 0), 1'b1);
        end
        tick();
        clear_all = 1'b1;
        for (int c = 0; c < NCH; c++)
            for (int i = 0; i < 16; i++) mem_m[c][i] = '0;
        tick();
        count_busy(5, nb);
        check_eq("clear_busy_len", nb, 16);
        wait_drain();
        tick(); rd1(1, 4'd7);
        tick(); rd1(2, 4'd5);

        // Reset while every channel is draining.
        for (int k = 0; k < 3; k++) begin
            tick();
            for (int c = 0; c < NCH; c++) push1(c, 4'd3, fz(k + 1, k + 1, k + 1), 1'b1);
        end
        tick();
        rst = 1'b0;
        reset_model();
        @(negedge clk);
        check_eq("rst2_out_valid", out_valid, 8'h00);
        check_eq("rst2_sat", sat_flag, 8'h00);
        check_eq("rst2_ovf", ovf_flag, 8'h00);
        check_eq("rst2_busy", busy, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        count_busy(-1, nb);
        check_eq("rst2_busy_len", nb, 16);
        check_eq("rst2_all_empty", all_empty, 1'b1);
        for (int c = 0; c < NCH; c++) begin
            tick();
            rd1(c, 4'd3);
        end
        for (int i = 0; i < 16; i++) begin
            tick();
            rd1(6, 4'(i));
        end
        repeat (4) tick();
        check_eq("sb_left", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
